// File: rtl/lcd_init_ctrl.sv
// HD44780-style 4-bit LCD controller: power-on init sequence, then user byte
// writes as two enable-strobed nibbles with command-dependent settle waits.
module lcd_init_ctrl #(
  parameter int unsigned PWRON_CYC      = 1500000,
  parameter int unsigned INIT_WAIT_CYC  = 410000,
  parameter int unsigned SHORT_WAIT_CYC = 10000,
  parameter int unsigned EN_SETUP_CYC   = 4,
  parameter int unsigned EN_PULSE_CYC   = 25,
  parameter int unsigned NIBBLE_GAP_CYC = 100,
  parameter int unsigned CMD_WAIT_CYC   = 4000,
  parameter int unsigned CLR_WAIT_CYC   = 164000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       IN_VALID,
  input  logic       IN_RS,
  input  logic [7:0] IN_DATA,
  output logic       IN_READY,
  output logic       INIT_DONE,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] LCD_D
);

  function automatic int unsigned at_least_1(input int unsigned v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned P_PWRON = at_least_1(PWRON_CYC);
  localparam int unsigned P_INIT  = at_least_1(INIT_WAIT_CYC);
  localparam int unsigned P_SHORT = at_least_1(SHORT_WAIT_CYC);
  localparam int unsigned P_SETUP = at_least_1(EN_SETUP_CYC);
  localparam int unsigned P_PULSE = at_least_1(EN_PULSE_CYC);
  localparam int unsigned P_GAP   = at_least_1(NIBBLE_GAP_CYC);
  localparam int unsigned P_CMD   = at_least_1(CMD_WAIT_CYC);
  localparam int unsigned P_CLR   = at_least_1(CLR_WAIT_CYC);

  localparam int unsigned MAX_CYC = max2(max2(max2(P_PWRON, P_INIT), max2(P_SHORT, P_GAP)),
                                         max2(max2(P_CMD, P_CLR), P_SETUP + P_PULSE));
  localparam int unsigned CNT_W   = max2($clog2(MAX_CYC + 1), 1);

  typedef enum logic [2:0] {
    PWRON, INIT_NIB, INIT_BYTE, IDLE, WR_HI, GAP, WR_LO, POST
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       nib_idx;
  logic [2:0]       byte_idx;
  logic             nib_hold;
  logic [7:0]       data_q;
  logic             rs_q;

  logic             pulse_rise;
  logic             pulse_end;
  logic [CNT_W-1:0] nib_wait_last;
  logic [CNT_W-1:0] post_last;
  logic             is_clr;
  logic [7:0]       init_byte;

  assign LCD_RW = 1'b0;

  always_comb begin
    pulse_rise    = (cnt == CNT_W'(P_SETUP - 1));
    pulse_end     = (cnt == CNT_W'(P_SETUP + P_PULSE - 1));
    nib_wait_last = (nib_idx == 2'd0) ? CNT_W'(P_INIT - 1) : CNT_W'(P_SHORT - 1);
    is_clr        = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02));
    post_last     = is_clr ? CNT_W'(P_CLR) : CNT_W'(P_CMD);
    case (byte_idx[1:0])
      2'd0:    init_byte = 8'h28;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= PWRON;
      cnt       <= '0;
      nib_idx   <= '0;
      byte_idx  <= '0;
      nib_hold  <= 1'b0;
      data_q    <= '0;
      rs_q      <= 1'b0;
      LCD_E     <= 1'b0;
      LCD_RS    <= 1'b0;
      LCD_D     <= '0;
      IN_READY  <= 1'b0;
      INIT_DONE <= 1'b0;
    end else begin
      case (state)
        PWRON: begin
          if (cnt == CNT_W'(P_PWRON - 1)) begin
            state    <= INIT_NIB;
            nib_idx  <= '0;
            nib_hold <= 1'b0;
            LCD_RS   <= 1'b0;
            LCD_D    <= 4'h3;
            cnt      <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // nib_hold splits each init nibble into its strobe and its settle wait
        INIT_NIB: begin
          if (!nib_hold) begin
            if (pulse_end) begin
              LCD_E    <= 1'b0;
              nib_hold <= 1'b1;
              cnt      <= '0;
            end else begin
              if (pulse_rise) LCD_E <= 1'b1;
              cnt <= cnt + CNT_W'(1);
            end
          end else if (cnt == nib_wait_last) begin
            cnt <= '0;
            if (nib_idx == 2'd3) begin
              state    <= INIT_BYTE;
              byte_idx <= '0;
            end else begin
              nib_idx  <= nib_idx + 2'd1;
              nib_hold <= 1'b0;
              LCD_D    <= (nib_idx == 2'd2) ? 4'h2 : 4'h3;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        INIT_BYTE: begin
          data_q   <= init_byte;
          rs_q     <= 1'b0;
          byte_idx <= byte_idx + 3'd1;
          LCD_RS   <= 1'b0;
          LCD_D    <= init_byte[7:4];
          cnt      <= '0;
          state    <= WR_HI;
        end

        IDLE: begin
          if (IN_VALID && IN_READY) begin
            data_q   <= IN_DATA;
            rs_q     <= IN_RS;
            IN_READY <= 1'b0;
            LCD_RS   <= IN_RS;
            LCD_D    <= IN_DATA[7:4];
            cnt      <= '0;
            state    <= WR_HI;
          end
        end

        WR_HI, WR_LO: begin
          if (pulse_end) begin
            LCD_E <= 1'b0;
            cnt   <= '0;
            state <= (state == WR_HI) ? GAP : POST;
          end else begin
            if (pulse_rise) LCD_E <= 1'b1;
            cnt <= cnt + CNT_W'(1);
          end
        end

        GAP: begin
          if (cnt == CNT_W'(P_GAP - 1)) begin
            LCD_D <= data_q[3:0];
            cnt   <= '0;
            state <= WR_LO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        // INIT_DONE shows in the expiry cycle itself; IN_READY one cycle later
        POST: begin
          if (cnt == post_last) begin
            cnt <= '0;
            if (INIT_DONE) begin
              state    <= IDLE;
              IN_READY <= 1'b1;
            end else begin
              state <= INIT_BYTE;
            end
          end else begin
            if (!INIT_DONE && (byte_idx == 3'd4) && (cnt == post_last - CNT_W'(1)))
              INIT_DONE <= 1'b1;
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= PWRON;
      endcase
    end
  end

endmodule
